// File: rtl/window_gen_3x3_pkg.sv
// Shared constants for the 3x3 window generator and the downstream filter stage.
// Window indices are row-major, 1-based: WIN_TL top-left through WIN_BR bottom-right.
package window_gen_3x3_pkg;

    localparam int unsigned DEF_PIX_W = 8;
    localparam int unsigned DEF_IMG_W = 128;
    localparam int unsigned DEF_IMG_H = 128;

    localparam int unsigned WIN_TL = 1;
    localparam int unsigned WIN_TM = 2;
    localparam int unsigned WIN_TR = 3;
    localparam int unsigned WIN_ML = 4;
    localparam int unsigned WIN_C  = 5;
    localparam int unsigned WIN_MR = 6;
    localparam int unsigned WIN_BL = 7;
    localparam int unsigned WIN_BM = 8;
    localparam int unsigned WIN_BR = 9;

endpackage

// File: rtl/window_gen_3x3_line_buf.sv
// One image line of pixel storage, indexed by column. Read is combinational and sees the
// old contents; a write on the same address lands at the clock edge (read-before-write).
module window_gen_3x3_line_buf
    import window_gen_3x3_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_IMG_W,
    parameter int unsigned WIDTH = DEF_PIX_W
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset; stale data is never exposed as a window.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/window_gen_3x3.sv
// Raster-stream to 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window,
// one window presented per accepted pixel once the window lies fully inside the image.
module window_gen_3x3
    import window_gen_3x3_pkg::*;
#(
    parameter int unsigned IMG_W = DEF_IMG_W,
    parameter int unsigned IMG_H = DEF_IMG_H,
    parameter int unsigned PIX_W = DEF_PIX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PIX_W-1:0]         in_pixel,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [PIX_W-1:0]         win1,
    output logic [PIX_W-1:0]         win2,
    output logic [PIX_W-1:0]         win3,
    output logic [PIX_W-1:0]         win4,
    output logic [PIX_W-1:0]         win5,
    output logic [PIX_W-1:0]         win6,
    output logic [PIX_W-1:0]         win7,
    output logic [PIX_W-1:0]         win8,
    output logic [PIX_W-1:0]         win9,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic                     frame_done
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_FIN  = COL_W'(IMG_W - 2);
    localparam logic [ROW_W-1:0] ROW_FIN  = ROW_W'(IMG_H - 2);

    logic             accept;
    logic             emit;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             win_valid_q, win_valid_d;
    logic [ROW_W-1:0] win_row_q, win_row_d;
    logic [COL_W-1:0] win_col_q, win_col_d;
    logic             frame_done_q, frame_done_d;
    logic [PIX_W-1:0] line1_rd, line2_rd;
    logic [PIX_W-1:0] win_q [3][3];
    logic [PIX_W-1:0] win_flat [WIN_TL:WIN_BR];

    assign in_ready = !win_valid_q || win_ready;
    assign accept   = in_valid && in_ready;
    // Only the first two rows/columns of a line leave the window partly outside the image.
    assign emit     = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

    window_gen_3x3_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_line1 (
        .clk   (clk),
        .wr_en (accept),
        .addr  (col_q),
        .wdata (in_pixel),
        .rdata (line1_rd)
    );

    window_gen_3x3_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_line2 (
        .clk   (clk),
        .wr_en (accept),
        .addr  (col_q),
        .wdata (line1_rd),
        .rdata (line2_rd)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        win_valid_d = win_valid_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        if (accept) begin
            win_valid_d = emit;
            if (emit) begin
                win_row_d = row_q - 1'b1;
                win_col_d = col_q - 1'b1;
            end
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_comb begin
        frame_done_d = win_valid_q && win_ready && (win_row_q == ROW_FIN) &&
                       (win_col_q == COL_FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Window shifts left on every accepted pixel; new right column is rows r-2, r-1, r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q[0][0] <= '0;
            win_q[0][1] <= '0;
            win_q[0][2] <= '0;
            win_q[1][0] <= '0;
            win_q[1][1] <= '0;
            win_q[1][2] <= '0;
            win_q[2][0] <= '0;
            win_q[2][1] <= '0;
            win_q[2][2] <= '0;
        end else if (accept) begin
            win_q[0][0] <= win_q[0][1];
            win_q[0][1] <= win_q[0][2];
            win_q[0][2] <= line2_rd;
            win_q[1][0] <= win_q[1][1];
            win_q[1][1] <= win_q[1][2];
            win_q[1][2] <= line1_rd;
            win_q[2][0] <= win_q[2][1];
            win_q[2][1] <= win_q[2][2];
            win_q[2][2] <= in_pixel;
        end
    end

    for (genvar gr = 0; gr < 3; gr++) begin : g_row
        for (genvar gc = 0; gc < 3; gc++) begin : g_col
            assign win_flat[WIN_TL + 3 * gr + gc] = win_q[gr][gc];
        end
    end

    assign win1       = win_flat[WIN_TL];
    assign win2       = win_flat[WIN_TM];
    assign win3       = win_flat[WIN_TR];
    assign win4       = win_flat[WIN_ML];
    assign win5       = win_flat[WIN_C];
    assign win6       = win_flat[WIN_MR];
    assign win7       = win_flat[WIN_BL];
    assign win8       = win_flat[WIN_BM];
    assign win9       = win_flat[WIN_BR];
    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3: directed 5x5 ramp frames driven from a window table, plus a
// randomly throttled 8x6 run checked against a direct image-indexing 3x3 model.
module tb_window_gen_3x3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 5x5 instance
    logic       a_in_valid, a_in_ready, a_win_valid, a_win_ready, a_fd;
    logic [7:0] a_in_pixel;
    logic [7:0] a_win [1:9];
    logic [2:0] a_row, a_col;

    // 8x6 instance
    logic       b_in_valid, b_in_ready, b_win_valid, b_win_ready, b_fd;
    logic [7:0] b_in_pixel;
    logic [7:0] b_win [1:9];
    logic [2:0] b_row, b_col;

    window_gen_3x3 #(.IMG_W(5), .IMG_H(5), .PIX_W(8)) u_dut5 (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_pixel(a_in_pixel), .win_valid(a_win_valid), .win_ready(a_win_ready),
        .win1(a_win[1]), .win2(a_win[2]), .win3(a_win[3]), .win4(a_win[4]),
        .win5(a_win[5]), .win6(a_win[6]), .win7(a_win[7]), .win8(a_win[8]),
        .win9(a_win[9]), .win_row(a_row), .win_col(a_col), .frame_done(a_fd)
    );

    window_gen_3x3 #(.IMG_W(8), .IMG_H(6), .PIX_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_pixel(b_in_pixel), .win_valid(b_win_valid), .win_ready(b_win_ready),
        .win1(b_win[1]), .win2(b_win[2]), .win3(b_win[3]), .win4(b_win[4]),
        .win5(b_win[5]), .win6(b_win[6]), .win7(b_win[7]), .win8(b_win[8]),
        .win9(b_win[9]), .win_row(b_row), .win_col(b_col), .frame_done(b_fd)
    );

    // stall = cycles win_ready is held low before this window is taken (stall runs only)
    typedef struct {
        int stall;
        int row;
        int col;
        int centre;
    } win_vec_t;

    win_vec_t   tab [9];
    int         first_win [9];
    logic [7:0] img [3][6][8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_win_valid"}, int'(a_win_valid), 0);
        check({tag, "_frame_done"}, int'(a_fd), 0);
        check({tag, "_win5"}, int'(a_win[5]), 0);
        check({tag, "_win_row"}, int'(a_row), 0);
        check({tag, "_win_col"}, int'(a_col), 0);
        check({tag, "_in_ready"}, int'(a_in_ready), 1);
    endtask

    // Ramp frames on the 5x5 instance: pixel value = frame*25 + row*5 + col.
    task automatic run5(input int nframes, input bit use_stall);
        int  p, wn, stalled, cyc, pulses, total, exp_c, off;
        bit  fd_exp;
        int  row_cnt [8];
        p = 0; wn = 0; stalled = 0; cyc = 0; pulses = 0; fd_exp = 1'b0;
        total = 25 * nframes;
        for (int i = 0; i < 8; i++) row_cnt[i] = 0;
        @(negedge clk);
        while (cyc < 300 * nframes) begin
            a_in_valid  = (p < total);
            a_in_pixel  = 8'(p);
            a_win_ready = 1'b1;
            if (use_stall && wn < 9 && a_win_valid && stalled < tab[wn].stall) a_win_ready = 1'b0;
            #1;
            check("frame_done", int'(a_fd), int'(fd_exp));
            fd_exp = 1'b0;
            if (a_win_valid && wn < 9 * nframes) begin
                exp_c = tab[wn % 9].centre + 25 * (wn / 9);
                if (!a_win_ready) begin
                    stalled++;
                    check("stall_in_ready", int'(a_in_ready), 0);
                    check("stall_win5", int'(a_win[5]), exp_c);
                    check("stall_win1", int'(a_win[1]), exp_c - 6);
                    check("stall_win9", int'(a_win[9]), exp_c + 6);
                    check("stall_win_col", int'(a_col), tab[wn % 9].col);
                end else begin
                    check("win_row", int'(a_row), tab[wn % 9].row);
                    check("win_col", int'(a_col), tab[wn % 9].col);
                    for (int k = 0; k < 9; k++) begin
                        off = (k / 3 - 1) * 5 + (k % 3 - 1);
                        check($sformatf("win%0d_w%0d", k + 1, wn), int'(a_win[k + 1]), exp_c + off);
                        if (wn == 0) check("first_win", int'(a_win[k + 1]), first_win[k]);
                    end
                    row_cnt[a_row]++;
                    if (wn % 9 == 8) fd_exp = 1'b1;
                    wn++;
                    stalled = 0;
                end
            end else if (a_win_valid) begin
                check("extra_window", 1, 0);
            end
            if (a_fd) pulses++;
            if (a_in_valid && a_in_ready) p++;
            cyc++;
            if (p == total && wn == 9 * nframes && pulses == nframes && !fd_exp) break;
            @(negedge clk);
        end
        a_in_valid = 1'b0;
        check("windows_total", wn, 9 * nframes);
        check("pixels_taken", p, total);
        check("frame_done_pulses", pulses, nframes);
        for (int r = 1; r <= 3; r++) check($sformatf("row%0d_windows", r), row_cnt[r], 3 * nframes);
        check("idle_win_valid", int'(a_win_valid), 0);
    endtask

    // Partial frame, then async reset mid-stream while a window is stalled.
    task automatic reset_mid();
        int p, cyc;
        p = 0; cyc = 0;
        @(negedge clk);
        a_win_ready = 1'b1;
        while (p < 13 && cyc < 100) begin
            a_in_valid = 1'b1;
            a_in_pixel = 8'(p);
            #1;
            if (a_in_ready) p++;
            cyc++;
            @(negedge clk);
        end
        a_in_valid  = 1'b1;
        a_in_pixel  = 8'(p);
        a_win_ready = 1'b0;
        #1;
        check("pre_rst_win_valid", int'(a_win_valid), 1);
        check("pre_rst_win5", int'(a_win[5]), 6);
        #1;
        rst = 1'b1;
        #1;
        check_reset_state("mid_rst");
        @(negedge clk);
        rst         = 1'b0;
        a_in_valid  = 1'b0;
        a_win_ready = 1'b1;
        #1;
        check("post_rst_in_ready", int'(a_in_ready), 1);
        check("post_rst_win_valid", int'(a_win_valid), 0);
    endtask

    // Three random 8x6 frames with random gaps on both handshakes.
    task automatic run_rand();
        int  p, wn, cyc, pulses, f, r, c, idx;
        bit  ok;
        p = 0; wn = 0; cyc = 0; pulses = 0;
        for (int fi = 0; fi < 3; fi++)
            for (int ri = 0; ri < 6; ri++)
                for (int ci = 0; ci < 8; ci++) img[fi][ri][ci] = 8'($urandom_range(0, 255));
        @(negedge clk);
        while (cyc < 4000) begin
            b_in_valid  = (p < 144) && ($urandom_range(0, 9) < 7);
            b_in_pixel  = (p < 144) ? img[p / 48][(p % 48) / 8][p % 8] : 8'd0;
            b_win_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (b_win_valid && b_win_ready) begin
                checks++;
                if (wn < 72) begin
                    f   = wn / 24;
                    idx = wn % 24;
                    r   = 1 + idx / 6;
                    c   = 1 + idx % 6;
                    ok  = (int'(b_row) == r) && (int'(b_col) == c);
                    for (int k = 0; k < 9; k++)
                        if (b_win[k + 1] !== img[f][r - 1 + k / 3][c - 1 + k % 3]) ok = 1'b0;
                    if (!ok) begin
                        failures++;
                        $display("FAIL rand_window %0d: got row=%0d col=%0d centre=%0d expected row=%0d col=%0d centre=%0d",
                                 wn, b_row, b_col, b_win[5], r, c, img[f][r][c]);
                    end
                end else begin
                    failures++;
                    $display("FAIL rand_extra_window: got window %0d expected at most 72", wn);
                end
                wn++;
            end
            if (b_fd) pulses++;
            if (b_in_valid && b_in_ready) p++;
            cyc++;
            if (p == 144 && wn == 72 && pulses == 3) break;
            @(negedge clk);
        end
        b_in_valid = 1'b0;
        check("rand_windows", wn, 72);
        check("rand_pixels", p, 144);
        check("rand_frame_done", pulses, 3);
    endtask

    initial begin
        tab[0] = '{0, 1, 1, 6};
        tab[1] = '{4, 1, 2, 7};
        tab[2] = '{0, 1, 3, 8};
        tab[3] = '{0, 2, 1, 11};
        tab[4] = '{0, 2, 2, 12};
        tab[5] = '{0, 2, 3, 13};
        tab[6] = '{0, 3, 1, 16};
        tab[7] = '{0, 3, 2, 17};
        tab[8] = '{0, 3, 3, 18};
        first_win = '{0, 1, 2, 5, 6, 7, 10, 11, 12};

        a_in_valid = 1'b0; a_in_pixel = '0; a_win_ready = 1'b1;
        b_in_valid = 1'b0; b_in_pixel = '0; b_win_ready = 1'b1;

        @(negedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        run5(1, 1'b0);
        run5(2, 1'b0);
        run5(1, 1'b1);
        reset_mid();
        run5(1, 1'b0);
        run_rand();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
